// File: rtl/fft_pkg.sv
// Shared constants, read-FSM state type and bit-reversal helper for the
// 32-point FFT output reorder buffer.
package fft_pkg;

  localparam int unsigned LOG2N  = 5;
  localparam int unsigned N      = 1 << LOG2N;
  localparam int unsigned DATA_W = 18;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } rd_state_e;

  function automatic logic [4:0] bitrev5(input logic [4:0] a);
    return {a[0], a[1], a[2], a[3], a[4]};
  endfunction

endpackage

// File: rtl/fft_pingpong_ram.sv
// Two-bank register-array frame buffer: one synchronous write port and one
// combinational read port, each with its own bank select.
module fft_pingpong_ram #(
  parameter int unsigned W  = 36,
  parameter int unsigned AW = 5
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic          wr_bank_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [W-1:0]  wr_data_i,
  input  logic          rd_bank_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [W-1:0]  rd_data_o
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [W-1:0] mem_q [2][DEPTH];

  // Contents are intentionally left uninitialised by reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[wr_bank_i][wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_bank_i][rd_addr_i];

endmodule

// File: rtl/fft32_out_reorder.sv
// Reorders bit-reversed FFT output frames into a gap-free natural-order stream
// through a ping-pong buffer, tagging each sample with its index and frame start.
module fft32_out_reorder #(
  parameter int unsigned DATA_W = 18,
  parameter int unsigned LOG2N  = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_i,
  input  logic signed [DATA_W-1:0] data_in_r,
  input  logic signed [DATA_W-1:0] data_in_i,
  output logic                     valid_o,
  output logic                     sop_o,
  output logic [LOG2N-1:0]         out_idx,
  output logic signed [DATA_W-1:0] data_out_r,
  output logic signed [DATA_W-1:0] data_out_i
);

  import fft_pkg::rd_state_e;
  import fft_pkg::IDLE;
  import fft_pkg::READ;
  import fft_pkg::bitrev5;

  localparam int unsigned      PW   = 2 * DATA_W;
  localparam logic [LOG2N-1:0] LAST = LOG2N'((1 << LOG2N) - 1);

  logic [LOG2N-1:0] wr_cnt_q, wr_cnt_d;
  logic             wr_bank_q, wr_bank_d;
  logic [1:0]       bank_full_q, bank_full_d;

  rd_state_e        state_q;
  logic             rd_bank_q;
  logic [LOG2N-1:0] rd_cnt_q;

  logic             wr_last_c;
  logic             rd_last_c;
  logic             other_full_c;
  logic             start_bank_c;
  logic             rd_bank_sel_c;
  logic [LOG2N-1:0] rd_addr_sel_c;
  logic [PW-1:0]    rd_data_c;
  logic [DATA_W-1:0] rd_re_c, rd_im_c;

  assign wr_last_c    = valid_i && (wr_cnt_q == LAST);
  assign rd_last_c    = (state_q == READ) && (rd_cnt_q == LAST);
  // A frame finishing into the other bank on this very edge must count, so
  // back-to-back frames hand off without a bubble.
  assign other_full_c = bank_full_q[~rd_bank_q] ||
                        (wr_last_c && (wr_bank_q != rd_bank_q));
  assign start_bank_c = ~bank_full_q[0];

  // IDLE fetches X[0] of the newly completed bank; READ walks rd_cnt.
  assign rd_bank_sel_c = (state_q == IDLE) ? start_bank_c : rd_bank_q;
  assign rd_addr_sel_c = (state_q == IDLE) ? '0 : rd_cnt_q;
  assign rd_re_c       = rd_data_c[PW-1:DATA_W];
  assign rd_im_c       = rd_data_c[DATA_W-1:0];

  fft_pingpong_ram #(
    .W  (PW),
    .AW (LOG2N)
  ) u_ram (
    .clk       (clk),
    .we_i      (valid_i),
    .wr_bank_i (wr_bank_q),
    .wr_addr_i (bitrev5(wr_cnt_q)),
    .wr_data_i ({data_in_r, data_in_i}),
    .rd_bank_i (rd_bank_sel_c),
    .rd_addr_i (rd_addr_sel_c),
    .rd_data_o (rd_data_c)
  );

  // Write counter, bank pointer and full flags (set by writer, cleared by reader).
  always_comb begin
    wr_cnt_d    = wr_cnt_q;
    wr_bank_d   = wr_bank_q;
    bank_full_d = bank_full_q;
    if (rd_last_c) begin
      bank_full_d[rd_bank_q] = 1'b0;
    end
    if (valid_i) begin
      wr_cnt_d = wr_cnt_q + LOG2N'(1);
      if (wr_last_c) begin
        bank_full_d[wr_bank_q] = 1'b1;
        wr_bank_d              = ~wr_bank_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt_q    <= '0;
      wr_bank_q   <= 1'b0;
      bank_full_q <= '0;
    end else begin
      wr_cnt_q    <= wr_cnt_d;
      wr_bank_q   <= wr_bank_d;
      bank_full_q <= bank_full_d;
    end
  end

  // Read FSM with registered stream outputs; data holds while valid_o is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rd_bank_q  <= 1'b0;
      rd_cnt_q   <= '0;
      valid_o    <= 1'b0;
      sop_o      <= 1'b0;
      out_idx    <= '0;
      data_out_r <= '0;
      data_out_i <= '0;
    end else begin
      sop_o <= 1'b0;
      unique case (state_q)
        IDLE: begin
          valid_o <= 1'b0;
          if (|bank_full_q) begin
            state_q    <= READ;
            rd_bank_q  <= start_bank_c;
            rd_cnt_q   <= LOG2N'(1);
            valid_o    <= 1'b1;
            sop_o      <= 1'b1;
            out_idx    <= '0;
            data_out_r <= $signed(rd_re_c);
            data_out_i <= $signed(rd_im_c);
          end
        end
        READ: begin
          valid_o    <= 1'b1;
          sop_o      <= (rd_cnt_q == '0);
          out_idx    <= rd_cnt_q;
          data_out_r <= $signed(rd_re_c);
          data_out_i <= $signed(rd_im_c);
          rd_cnt_q   <= rd_cnt_q + LOG2N'(1);
          if (rd_last_c) begin
            if (other_full_c) begin
              rd_bank_q <= ~rd_bank_q;
            end else begin
              state_q <= IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft32_out_reorder.sv
// Directed bench for fft32_out_reorder: single, back-to-back, gapped, extreme
// and reset scenarios with hand-derived expected natural-order streams.
module tb_fft32_out_reorder;

  localparam int MAXV = 131071;
  localparam int MINV = -131072;

  logic              clk;
  logic              rst;
  logic              valid_i;
  logic signed [17:0] data_in_r;
  logic signed [17:0] data_in_i;
  logic              valid_o;
  logic              sop_o;
  logic [4:0]        out_idx;
  logic signed [17:0] data_out_r;
  logic signed [17:0] data_out_i;

  int n_cmp;
  int n_fail;

  fft32_out_reorder #(
    .DATA_W (18),
    .LOG2N  (5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_i    (valid_i),
    .data_in_r  (data_in_r),
    .data_in_i  (data_in_i),
    .valid_o    (valid_o),
    .sop_o      (sop_o),
    .out_idx    (out_idx),
    .data_out_r (data_out_r),
    .data_out_i (data_out_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic int br(input int k);
    int r;
    r = 0;
    for (int i = 0; i < 5; i++) begin
      if (k[i]) r = r | (1 << (4 - i));
    end
    return r;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_inv();
    if (rst == 1'b0) begin
      chk("inv_idle_both_full",
          int'((dut.state_q == fft_pkg::IDLE) && (dut.bank_full_q == 2'b11)), 0);
      chk("inv_write_full_bank",
          int'(valid_i && dut.bank_full_q[dut.wr_bank_q]), 0);
    end
  endtask

  // Drive one input cycle, let one rising edge pass, return on the falling edge.
  task automatic step(input bit v, input int re, input int im);
    valid_i   = v;
    data_in_r = 18'(re);
    data_in_i = 18'(im);
    chk_inv();
    @(negedge clk);
  endtask

  task automatic exp_out(input string tag, input bit v, input bit s,
                         input int idx, input int re, input int im);
    chk({tag, ".valid"}, int'(valid_o), int'(v));
    if (v) begin
      chk({tag, ".sop"}, int'(sop_o), int'(s));
      chk({tag, ".idx"}, int'(out_idx), idx);
      chk({tag, ".re"}, int'(data_out_r), re);
      chk({tag, ".im"}, int'(data_out_i), im);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".valid"}, int'(valid_o), 0);
    chk({tag, ".sop"}, int'(sop_o), 0);
    chk({tag, ".idx"}, int'(out_idx), 0);
    chk({tag, ".re"}, int'(data_out_r), 0);
    chk({tag, ".im"}, int'(data_out_i), 0);
  endtask

  // Sample k carries natural index br(k): value base+n, imaginary -(base+n).
  task automatic feed_frame(input string tag, input int base);
    for (int k = 0; k < 32; k++) begin
      step(1'b1, base + br(k), -(base + br(k)));
      exp_out(tag, 1'b0, 1'b0, 0, 0, 0);
    end
  endtask

  task automatic read_frame(input string tag, input int base);
    for (int n = 0; n < 32; n++) begin
      step(1'b0, 0, 0);
      exp_out(tag, 1'b1, n == 0, n, base + n, -(base + n));
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_fail    = 0;
    rst       = 1'b1;
    valid_i   = 1'b0;
    data_in_r = '0;
    data_in_i = '0;

    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    // Single frame, output one cycle after the last input, then held.
    feed_frame("single_in", 0);
    read_frame("single_out", 0);
    step(1'b0, 0, 0);
    exp_out("single_end", 1'b0, 1'b0, 0, 0, 0);
    chk("single_hold.idx", int'(out_idx), 31);
    chk("single_hold.re", int'(data_out_r), 31);
    chk("single_hold.sop", int'(sop_o), 0);
    step(1'b0, 0, 0);
    exp_out("single_idle", 1'b0, 1'b0, 0, 0, 0);

    // Four continuous frames: output index o = t-32, gap-free for 128 cycles.
    for (int t = 0; t < 162; t++) begin
      int o;
      if (t < 128) step(1'b1, 100 * (t / 32) + br(t % 32), -(100 * (t / 32) + br(t % 32)));
      else step(1'b0, 0, 0);
      o = t - 32;
      if (o >= 0 && o < 128)
        exp_out("b2b", 1'b1, (o % 32) == 0, o % 32, 100 * (o / 32) + o % 32,
                -(100 * (o / 32) + o % 32));
      else
        exp_out("b2b_idle", 1'b0, 1'b0, 0, 0, 0);
    end

    // Gapped input 1,0,0; junk data on idle cycles must be ignored.
    for (int c = 0; c < 94; c++) begin
      if (c % 3 == 0) step(1'b1, br(c / 3), -br(c / 3));
      else step(1'b0, 12345, -999);
      exp_out("gap_in", 1'b0, 1'b0, 0, 0, 0);
    end
    read_frame("gap_out", 0);
    step(1'b0, 0, 0);
    exp_out("gap_end", 1'b0, 1'b0, 0, 0, 0);

    // Full-scale alternating values pass through with sign intact.
    for (int k = 0; k < 32; k++) begin
      int n;
      n = br(k);
      step(1'b1, (n % 2 == 0) ? MAXV : MINV, (n % 2 == 0) ? MINV : MAXV);
    end
    for (int n = 0; n < 32; n++) begin
      step(1'b0, 0, 0);
      exp_out("extreme", 1'b1, n == 0, n, (n % 2 == 0) ? MAXV : MINV,
              (n % 2 == 0) ? MINV : MAXV);
    end
    step(1'b0, 0, 0);

    // Reset after 17 samples: outputs clear at once, next frame aligns cleanly.
    for (int k = 0; k < 17; k++) step(1'b1, 777 + k, -(777 + k));
    valid_i = 1'b0;
    #2 rst = 1'b1;
    #1 chk_zero("rst_midframe");
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    feed_frame("rst_mf_in", 200);
    read_frame("rst_mf_out", 200);
    step(1'b0, 0, 0);
    exp_out("rst_mf_end", 1'b0, 1'b0, 0, 0, 0);

    // Reset while X[10] is on the output: readout truncated, no stale frame.
    feed_frame("rst_rd_in", 300);
    for (int n = 0; n <= 10; n++) begin
      step(1'b0, 0, 0);
      exp_out("rst_rd_pre", 1'b1, n == 0, n, 300 + n, -(300 + n));
    end
    #2 rst = 1'b1;
    #1 chk_zero("rst_midread");
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step(1'b0, 0, 0);
      exp_out("rst_rd_idle", 1'b0, 1'b0, 0, 0, 0);
    end
    feed_frame("rst_rd_in2", 400);
    read_frame("rst_rd_out", 400);
    step(1'b0, 0, 0);
    exp_out("rst_rd_end", 1'b0, 1'b0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fft32_out_reorder.md
Name: fft32_out_reorder

Overview:
- Consumer at the output end of the 32-point radix-2 SDF FFT pipeline.
- The final butterfly stage emits each 32-sample frame in bit-reversed index order. This block writes the frame into a ping-pong buffer at bit-reversed addresses and reads it back in natural order (X[0]..X[31]).
- It emits a continuous natural-order stream with a frame-start marker and an index tag. It applies no backpressure: the pipeline never stalls.

Parameters:
- DATA_W, 18, width of the real and imaginary parts (signed two's complement).
- LOG2N, 5, log2 of the FFT size. The block is verified only at 5, giving N = 32.

Ports:
- clk, input, 1, single clock; all state updates on its rising edge.
- rst, input, 1, asynchronous, active-high reset.
- valid_i, input, 1, qualifies data_in_r/i for one sample; gaps allowed.
- data_in_r, input, DATA_W, real part, bit-reversed order.
- data_in_i, input, DATA_W, imaginary part, bit-reversed order.
- valid_o, output, 1, data_out_r/i/out_idx valid this cycle.
- sop_o, output, 1, high with X[0] of each frame.
- out_idx, output, LOG2N, natural frequency index of the current output.
- data_out_r, output, DATA_W, real part, natural order.
- data_out_i, output, DATA_W, imaginary part, natural order.

Behaviour:
- Reset (async, rst=1):
  - valid_o=0, sop_o=0, out_idx=0, data_out_r/i=0.
  - wr_cnt=0, wr_bank=0, both bank_full flags=0, read FSM=IDLE.
  - Memory contents are not cleared.
  - A partial frame in flight at reset is discarded; a frame mid-readout is truncated with no further valid_o.
- Write side:
  - On each edge with valid_i=1: bank[wr_bank][bitrev5(wr_cnt)] <= data_in; wr_cnt <= wr_cnt+1 (wraps 31->0).
  - When wr_cnt==31 is written: set bank_full[wr_bank] and toggle wr_bank on the same edge.
  - valid_i=0 leaves all write state unchanged. Frame boundaries come only from the sample count; there is no sync input.
- Read FSM, states IDLE and READ, with rd_bank and rd_cnt:
  - IDLE -> READ on the edge after any bank_full is seen set. That edge emits X[0] of that bank: valid_o=1, sop_o=1, out_idx=0.
  - In READ, each edge emits bank[rd_bank][rd_cnt] on registered outputs and increments rd_cnt.
  - At rd_cnt==31: clear bank_full[rd_bank].
    - If the other bank is full, stay in READ, toggle rd_bank and restart at index 0 on the next edge. There is no bubble: back-to-back frames give gap-free output.
    - Otherwise go to IDLE; valid_o=0 from the next edge.
  - The memory read is combinational from the register array; data_out is registered. Data is valid in the same cycle as valid_o.
- Latency: if sample 31 of a frame is captured at edge E, X[0] appears (valid_o=1) at edge E+1 and X[31] at E+32.
- Simultaneous events:
  - Writing the last sample of bank B on the same edge the FSM emits X[31] of bank A is legal. The FSM must take the READ->READ handoff.
  - Writing into a bank and reading from the other bank on the same edge is always legal.
- Invariant: a bank is never written while its bank_full flag is set, and both flags are never set with the FSM in IDLE. This holds by construction because input rate ≤ 1 sample/cycle. The bench asserts it.
- When valid_o=0, data_out_r/i and out_idx hold their last values. sop_o is a one-cycle pulse.
- Arithmetic: none. Data passes bit-exact, signed DATA_W in and out.

Decomposition:
- Shared package fft_pkg:
  - constants LOG2N=5, N=32, default DATA_W;
  - function bitrev5;
  - read-FSM state enum {IDLE, READ}.
- One natural sub-module: fft_pingpong_ram.
  - Two banks of N x 2·DATA_W registers, one write port (bank, addr, data, we) and one combinational read port (bank, addr).
  - The top level holds the counters, flags and FSM.

Test Plan:
- Single frame: feed 32 samples, one per cycle; sample k has re=bitrev5(k), im=-bitrev5(k). Outputs X[n] re=n, im=-n for n=0..31. valid_o starts 1 cycle after the last input. sop_o is high only with out_idx=0.
- Back-to-back frames: 4 continuous frames, frame f value = 100·f + natural index. valid_o stays high for 128 consecutive cycles with no bubble, and sop_o pulses every 32 cycles.
- Gapped input: valid_i pattern 1,0,0 repeating over one frame. Output is unchanged vs. the single-frame case, starting 1 cycle after the 32nd valid sample. No output appears before then.
- Extremes: data = +(2^17-1) and -2^17 alternating. Values pass bit-exact with the sign preserved.
- Reset mid-frame: after 17 input samples assert rst for 2 cycles. All outputs are 0 immediately (async). A following full frame reorders correctly, and no residue from the 17 samples appears.
- Reset mid-readout: assert rst at out_idx=10. valid_o drops at once and stays 0 until the next complete frame is received.
